// File: rtl/p_d_cache_control_nway.sv
// Write-back N-way D-cache controller with tree pseudo-LRU.
// Victim way is latched at miss time; refill is followed by a re-read cycle.
module p_d_cache_control_nway #(
    parameter  int WAYS = 4,
    localparam int WIDX = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            mem_resp,
    input  logic            pmem_resp,
    output logic            pmem_read,
    output logic            pmem_write,
    input  logic [WAYS-1:0] hit_vec,
    input  logic [WAYS-1:0] valid_vec,
    input  logic [WAYS-1:0] dirty_vec,
    input  logic [WAYS-2:0] plru_in,
    output logic            plru_load,
    output logic [WAYS-2:0] plru_out,
    output logic [WAYS-1:0] valid_load,
    output logic [WAYS-1:0] dirty_load,
    output logic            dirty_datain,
    output logic [WAYS-1:0] tag_load,
    output logic [WAYS-1:0] fill_we,
    output logic [WAYS-1:0] cpu_we,
    output logic [WIDX-1:0] wb_way,
    output logic            pmem_addr_sel,
    output logic            addr_sel,
    output logic            pipe_stall,
    output logic            array_read_en
);

    localparam logic [1:0] LOOKUP     = 2'd0;
    localparam logic [1:0] WRITE_BACK = 2'd1;
    localparam logic [1:0] REFILL     = 2'd2;
    localparam logic [1:0] RESTART    = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [WIDX-1:0] victim_q;
    logic [WIDX-1:0] victim_d;
    logic [WIDX-1:0] hit_way;
    logic [WIDX-1:0] inv_way;
    logic [WIDX-1:0] plru_way;
    logic [WIDX-1:0] victim;
    logic            inv_found;
    logic            req;
    logic            hit;
    logic [WAYS-1:0] hit_oh;
    logic [WAYS-1:0] vic_oh;

    assign req    = mem_read | mem_write;
    assign hit    = |hit_vec;
    assign hit_oh = WAYS'(1) << hit_way;
    assign vic_oh = WAYS'(1) << victim_q;

    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (hit_vec[i])
                hit_way = WIDX'(i);
    end

    // Walk up from the hit leaf, pointing each ancestor away from it.
    always_comb begin
        int n;
        int p;
        plru_out = plru_in;
        n = int'(hit_way) + WAYS - 1;
        for (int l = 0; l < WIDX; l++) begin
            p = (n - 1) / 2;
            for (int j = 0; j < WAYS - 1; j++)
                if (j == p)
                    plru_out[j] = n[0];
            n = p;
        end
    end

    always_comb begin
        int   node;
        logic b;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid_vec[i]) begin
                inv_found = 1'b1;
                inv_way   = WIDX'(i);
            end
        node = 0;
        for (int l = 0; l < WIDX; l++) begin
            b = 1'b0;
            for (int j = 0; j < WAYS - 1; j++)
                if (j == node)
                    b = plru_in[j];
            node = 2 * node + 1 + int'(b);
        end
        plru_way = WIDX'(node - (WAYS - 1));
        victim   = inv_found ? inv_way : plru_way;
    end

    always_comb begin
        state_d       = state;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        plru_load     = 1'b0;
        valid_load    = '0;
        dirty_load    = '0;
        dirty_datain  = 1'b0;
        tag_load      = '0;
        fill_we       = '0;
        cpu_we        = '0;
        wb_way        = victim_q;
        pmem_addr_sel = 1'b0;
        addr_sel      = 1'b0;
        pipe_stall    = 1'b0;
        array_read_en = 1'b0;
        if (!rst) begin
            array_read_en = 1'b1;
        end else begin
            unique case (state)
                LOOKUP: begin
                    array_read_en = 1'b1;
                    if (req && hit) begin
                        mem_resp  = 1'b1;
                        plru_load = 1'b1;
                        if (mem_write) begin
                            cpu_we       = hit_oh;
                            dirty_load   = hit_oh;
                            dirty_datain = 1'b1;
                        end
                    end else if (req) begin
                        pipe_stall = 1'b1;
                        addr_sel   = 1'b1;
                        victim_d   = victim;
                        if (valid_vec[victim] && dirty_vec[victim])
                            state_d = WRITE_BACK;
                        else
                            state_d = REFILL;
                    end
                end
                WRITE_BACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    pipe_stall    = 1'b1;
                    addr_sel      = 1'b1;
                    if (pmem_resp)
                        state_d = REFILL;
                end
                REFILL: begin
                    pmem_read  = 1'b1;
                    pipe_stall = 1'b1;
                    addr_sel   = 1'b1;
                    if (pmem_resp) begin
                        tag_load   = vic_oh;
                        valid_load = vic_oh;
                        dirty_load = vic_oh;
                        fill_we    = vic_oh;
                        state_d    = RESTART;
                    end
                end
                RESTART: begin
                    pipe_stall    = 1'b1;
                    addr_sel      = 1'b1;
                    array_read_en = 1'b1;
                    state_d       = LOOKUP;
                end
                default: state_d = LOOKUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOOKUP;
            victim_q <= '0;
        end else begin
            state    <= state_d;
            victim_q <= victim_d;
        end
    end

endmodule

// File: tb/tb_p_d_cache_control_nway.sv
// Randomized bench for the N-way D-cache controller against a
// range-halving PLRU model and a cycle-level miss timeline.
module tb_p_d_cache_control_nway;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-way instance
    logic       mem_read, mem_write, mem_resp;
    logic       pmem_resp, pmem_read, pmem_write;
    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic [2:0] plru_in, plru_out;
    logic       plru_load, dirty_datain;
    logic [3:0] valid_load, dirty_load, tag_load;
    logic [3:0] fill_we, cpu_we;
    logic [1:0] wb_way;
    logic       pmem_addr_sel, addr_sel;
    logic       pipe_stall, array_read_en;

    // 8-way instance
    logic       mem_read8, mem_write8, mem_resp8;
    logic       pmem_resp8, pmem_read8, pmem_write8;
    logic [7:0] hit_vec8, valid_vec8, dirty_vec8;
    logic [6:0] plru_in8, plru_out8;
    logic       plru_load8, dirty_datain8;
    logic [7:0] valid_load8, dirty_load8, tag_load8;
    logic [7:0] fill_we8, cpu_we8;
    logic [2:0] wb_way8;
    logic       pmem_addr_sel8, addr_sel8;
    logic       pipe_stall8, array_read_en8;

    p_d_cache_control_nway #(.WAYS(4)) u4 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_resp(pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .hit_vec(hit_vec), .valid_vec(valid_vec),
        .dirty_vec(dirty_vec), .plru_in(plru_in),
        .plru_load(plru_load), .plru_out(plru_out),
        .valid_load(valid_load), .dirty_load(dirty_load),
        .dirty_datain(dirty_datain), .tag_load(tag_load),
        .fill_we(fill_we), .cpu_we(cpu_we), .wb_way(wb_way),
        .pmem_addr_sel(pmem_addr_sel), .addr_sel(addr_sel),
        .pipe_stall(pipe_stall), .array_read_en(array_read_en)
    );

    p_d_cache_control_nway #(.WAYS(8)) u8 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read8), .mem_write(mem_write8),
        .mem_resp(mem_resp8), .pmem_resp(pmem_resp8),
        .pmem_read(pmem_read8), .pmem_write(pmem_write8),
        .hit_vec(hit_vec8), .valid_vec(valid_vec8),
        .dirty_vec(dirty_vec8), .plru_in(plru_in8),
        .plru_load(plru_load8), .plru_out(plru_out8),
        .valid_load(valid_load8), .dirty_load(dirty_load8),
        .dirty_datain(dirty_datain8), .tag_load(tag_load8),
        .fill_we(fill_we8), .cpu_we(cpu_we8), .wb_way(wb_way8),
        .pmem_addr_sel(pmem_addr_sel8), .addr_sel(addr_sel8),
        .pipe_stall(pipe_stall8), .array_read_en(array_read_en8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Lowest invalid way, else descend the tree by halving the way range.
    function automatic int ref_victim(input int ways, input int v,
                                      input int p);
        int lo, size, node;
        bit found;
        found = 0;
        lo    = 0;
        for (int i = ways - 1; i >= 0; i--)
            if (((v >> i) & 1) == 0) begin
                found = 1;
                lo    = i;
            end
        if (!found) begin
            size = ways;
            node = 0;
            while (size > 1) begin
                size = size / 2;
                if (((p >> node) & 1) == 1) begin
                    lo   = lo + size;
                    node = 2 * node + 2;
                end else begin
                    node = 2 * node + 1;
                end
            end
        end
        return lo;
    endfunction

    // Each node on the way's path points to the half not holding it.
    function automatic int ref_plru(input int ways, input int w,
                                    input int p);
        int lo, size, node, r;
        lo   = 0;
        size = ways;
        node = 0;
        r    = p;
        while (size > 1) begin
            size = size / 2;
            if (w >= lo + size) begin
                r    = r & ~(1 << node);
                lo   = lo + size;
                node = 2 * node + 2;
            end else begin
                r    = r | (1 << node);
                node = 2 * node + 1;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        mem_read  = 0;
        mem_write = 0;
        hit_vec   = 0;
        pmem_resp = 0;
    endtask

    task automatic hit4(input int way, input bit wr, input int p);
        int oh;
        oh        = 1 << way;
        mem_read  = !wr || ($urandom_range(1) == 1);
        mem_write = wr;
        hit_vec   = 4'(oh);
        valid_vec = 4'($urandom) | 4'(oh);
        dirty_vec = 4'($urandom);
        plru_in   = 3'(p);
        pmem_resp = 1'($urandom);
        #1;
        chk("hit_resp", mem_resp, 1);
        chk("hit_stall", pipe_stall, 0);
        chk("hit_plru_ld", plru_load, 1);
        chk("hit_plru", plru_out, ref_plru(4, way, p));
        chk("hit_cpu_we", cpu_we, wr ? oh : 0);
        chk("hit_dirty_ld", dirty_load, wr ? oh : 0);
        if (wr) chk("hit_dirty_in", dirty_datain, 1);
        chk("hit_pmem", {pmem_read, pmem_write}, 0);
        tick();
    endtask

    task automatic miss4(input int v, input int d, input int p,
                         input bit wr, input int lwb, input int lrf);
        int vic, voh;
        bit dty;
        vic = ref_victim(4, v, p);
        voh = 1 << vic;
        dty = (((v >> vic) & 1) == 1) && (((d >> vic) & 1) == 1);
        mem_read  = !wr || ($urandom_range(1) == 1);
        mem_write = wr;
        hit_vec   = 0;
        valid_vec = 4'(v);
        dirty_vec = 4'(d);
        plru_in   = 3'(p);
        pmem_resp = 0;
        #1;
        chk("miss_stall", pipe_stall, 1);
        chk("miss_addr_sel", addr_sel, 1);
        chk("miss_resp", mem_resp, 0);
        chk("miss_pmem", {pmem_read, pmem_write}, 0);
        tick();
        // Set state changes under the held miss; victim must not move.
        valid_vec = 4'($urandom);
        dirty_vec = 4'($urandom);
        plru_in   = 3'($urandom);
        if (dty) begin
            for (int k = 0; k <= lwb; k++) begin
                pmem_resp = (k == lwb);
                #1;
                chk("wb_pmem", {pmem_read, pmem_write}, 1);
                chk("wb_way", wb_way, vic);
                chk("wb_addr_sel", pmem_addr_sel, 1);
                chk("wb_stall", pipe_stall, 1);
                chk("wb_fill", fill_we, 0);
                tick();
            end
        end
        for (int k = 0; k <= lrf; k++) begin
            pmem_resp = (k == lrf);
            #1;
            chk("rf_pmem", {pmem_read, pmem_write}, 2);
            chk("rf_addr_sel", pmem_addr_sel, 0);
            chk("rf_stall", pipe_stall, 1);
            chk("rf_fill", fill_we, (k == lrf) ? voh : 0);
            chk("rf_tag", tag_load, (k == lrf) ? voh : 0);
            chk("rf_valid", valid_load, (k == lrf) ? voh : 0);
            chk("rf_dirty", dirty_load, (k == lrf) ? voh : 0);
            if (k == lrf) chk("rf_dirty_in", dirty_datain, 0);
            tick();
        end
        pmem_resp = 0;
        #1;
        chk("rs_stall", pipe_stall, 1);
        chk("rs_read_en", array_read_en, 1);
        chk("rs_pmem", {pmem_read, pmem_write}, 0);
        chk("rs_writes", {fill_we, tag_load, valid_load}, 0);
        chk("rs_resp", mem_resp, 0);
        tick();
        hit_vec   = 4'(voh);
        valid_vec = 4'(v | voh);
        dirty_vec = 4'(d);
        plru_in   = 3'(p);
        #1;
        chk("rp_resp", mem_resp, 1);
        chk("rp_stall", pipe_stall, 0);
        chk("rp_plru", plru_out, ref_plru(4, vic, p));
        chk("rp_cpu_we", cpu_we, wr ? voh : 0);
        tick();
        idle4();
    endtask

    initial begin
        int w, p;
        idle4();
        valid_vec  = 0;
        dirty_vec  = 0;
        plru_in    = 0;
        mem_read8  = 0;
        mem_write8 = 0;
        pmem_resp8 = 0;
        hit_vec8   = 0;
        valid_vec8 = 0;
        dirty_vec8 = 0;
        plru_in8   = 0;
        mem_write  = 1;
        hit_vec    = 4'b0010;
        #2;
        chk("rst_resp", mem_resp, 0);
        chk("rst_cpu_we", cpu_we, 0);
        chk("rst_plru_ld", plru_load, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_addr_sel", addr_sel, 0);
        chk("rst_read_en", array_read_en, 1);
        chk("rst_pmem", {pmem_read, pmem_write}, 0);
        tick();
        tick();
        rst = 1;
        idle4();
        #1;
        chk("idle_stall", pipe_stall, 0);

        miss4(0, 0, 0, 0, 0, 3);
        miss4(15, 0, 0, 0, 0, 1);
        miss4(15, 0, 5, 0, 0, 0);
        miss4(15, 4'b0100, 1, 0, 2, 1);
        hit4(1, 1, $urandom_range(7));

        for (int i = 0; i < 10; i++) begin
            w          = $urandom_range(7);
            p          = $urandom_range(127);
            mem_read8  = 1;
            mem_write8 = 1'($urandom);
            hit_vec8   = 8'(1 << w);
            valid_vec8 = 8'hff;
            plru_in8   = 7'(p);
            #1;
            chk("h8_resp", mem_resp8, 1);
            chk("h8_stall", pipe_stall8, 0);
            chk("h8_plru", plru_out8, ref_plru(8, w, p));
            chk("h8_victim_sel", ref_victim(8, 8'hff, p) < 8, 1);
            tick();
        end
        mem_read8  = 0;
        mem_write8 = 0;
        hit_vec8   = 0;

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1)
                miss4($urandom_range(15), $urandom_range(15),
                      $urandom_range(7), 1'($urandom),
                      $urandom_range(3), $urandom_range(3));
            else
                hit4($urandom_range(3), 1'($urandom), $urandom_range(7));
        end

        mem_read  = 1;
        hit_vec   = 0;
        valid_vec = 4'hf;
        dirty_vec = 0;
        plru_in   = 0;
        tick();
        #1;
        chk("mr_pmem_read", pmem_read, 1);
        rst = 0;
        #1;
        chk("mr_rst_pmem", {pmem_read, pmem_write}, 0);
        chk("mr_rst_stall", pipe_stall, 0);
        pmem_resp = 1;
        #1;
        chk("mr_rst_writes", {tag_load, valid_load, fill_we}, 0);
        tick();
        rst = 1;
        idle4();
        pmem_resp = 1;
        #1;
        chk("mr_idle_pmem", {pmem_read, pmem_write}, 0);
        chk("mr_idle_fill", fill_we, 0);
        chk("mr_idle_stall", pipe_stall, 0);
        tick();
        hit4(2, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
